// File: rtl/btn_input_pkg.sv
// Shared types and constants for the pushbutton input block.
`timescale 1ns/1ps
package btn_input_pkg;

    // Debounce FSM states, one instance per button.
    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HIGH,
        S_HIGH,
        S_WAIT_LOW
    } btn_db_state_t;

    // Register offsets relative to BASE_ADDR.
    localparam logic [7:0] REG_LEVEL  = 8'd0;
    localparam logic [7:0] REG_STICKY = 8'd1;
    localparam logic [7:0] REG_MASK   = 8'd2;
    localparam logic [7:0] REG_COUNT  = 8'd3;

    // Stable-cycle compare points: 10 ms at 100 MHz, and a short one for simulation.
    localparam logic [25:0] DEBOUNCE_CNT_HW  = 26'd999999;
    localparam logic [25:0] DEBOUNCE_CNT_SIM = 26'd4;

endpackage

// File: rtl/btn_input_ctrl_if.sv
// Simple register-port bus between the processor and the button block.
`timescale 1ns/1ps
interface btn_input_ctrl_if;
    logic [7:0] BUS_ADDR;
    logic       BUS_RD;
    logic       BUS_WE;
    logic [7:0] BUS_WDATA;
    logic [7:0] BUS_RDATA;
    logic       BUS_RVALID;

    modport master (
        output BUS_ADDR, BUS_RD, BUS_WE, BUS_WDATA,
        input  BUS_RDATA, BUS_RVALID
    );

    modport slave (
        input  BUS_ADDR, BUS_RD, BUS_WE, BUS_WDATA,
        output BUS_RDATA, BUS_RVALID
    );
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, debounce FSM with stability counter,
// registered level and one-cycle press pulse.
`timescale 1ns/1ps
module btn_debounce
    import btn_input_pkg::*;
#(
    parameter logic [25:0] DEBOUNCE_CNT = DEBOUNCE_CNT_HW
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    logic          sync1_q;
    logic          sync2_q;
    btn_db_state_t state_q;
    logic [25:0]   cnt_q;
    logic          level_q;
    logic          press_q;

    // Synchronise the raw level, then run the debounce FSM on the synchronised copy.
    // The counter only advances while below the compare point, so it never wraps.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            case (state_q)
                S_LOW: begin
                    if (sync2_q) begin
                        state_q <= S_WAIT_HIGH;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT_HIGH: begin
                    if (!sync2_q) begin
                        state_q <= S_LOW;
                    end else if (cnt_q == DEBOUNCE_CNT) begin
                        state_q <= S_HIGH;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 26'd1;
                    end
                end
                S_HIGH: begin
                    if (!sync2_q) begin
                        state_q <= S_WAIT_LOW;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT_LOW: begin
                    if (sync2_q) begin
                        state_q <= S_HIGH;
                    end else if (cnt_q == DEBOUNCE_CNT) begin
                        state_q <= S_LOW;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 26'd1;
                    end
                end
                default: state_q <= S_LOW;
            endcase
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/btn_input_ctrl.sv
// Pushbutton input block: per-button debouncers plus the LEVEL/STICKY/MASK
// register set, bus read/write decode and the masked press interrupt.
`timescale 1ns/1ps
module btn_input_ctrl
    import btn_input_pkg::*;
#(
    parameter int          NUM_BTN      = 4,
    parameter logic [25:0] DEBOUNCE_CNT = DEBOUNCE_CNT_HW,
    parameter logic [7:0]  BASE_ADDR    = 8'hC0
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] BTN_IN,
    btn_input_ctrl_if.slave    bus,
    output logic [NUM_BTN-1:0] BTN_LEVEL,
    output logic [NUM_BTN-1:0] BTN_PRESS,
    output logic               IRQ
);

    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] press_w;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT)
        ) u_db (
            .clk_sys (clk_sys),
            .rst_n   (rst_n),
            .btn_i   (BTN_IN[gi]),
            .level_o (level_w[gi]),
            .press_o (press_w[gi])
        );
    end

    // Address decode: the offset wraps in 8 bits, so anything outside +0..+2 misses.
    logic [7:0] offset_w;
    logic       rd_hit_w;
    logic       rd_sticky_w;
    logic       we_mask_w;

    assign offset_w    = bus.BUS_ADDR - BASE_ADDR;
    assign rd_hit_w    = bus.BUS_RD && (offset_w < REG_COUNT);
    assign rd_sticky_w = bus.BUS_RD && (offset_w == REG_STICKY);
    assign we_mask_w   = bus.BUS_WE && (offset_w == REG_MASK);

    logic [NUM_BTN-1:0] sticky_q, sticky_d;
    logic [NUM_BTN-1:0] mask_q, mask_d;
    logic [7:0]         rdata_q, rd_mux_d;
    logic               rvalid_q;
    logic               irq_q;

    // Read mux and next-state for sticky/mask; a press in the clearing cycle survives.
    always_comb begin
        rd_mux_d = '0;
        case (offset_w)
            REG_LEVEL:  rd_mux_d[NUM_BTN-1:0] = level_w;
            REG_STICKY: rd_mux_d[NUM_BTN-1:0] = sticky_q;
            REG_MASK:   rd_mux_d[NUM_BTN-1:0] = mask_q;
            default:    rd_mux_d = '0;
        endcase
        sticky_d = (sticky_q & ~(rd_sticky_w ? sticky_q : '0)) | press_w;
        mask_d   = we_mask_w ? bus.BUS_WDATA[NUM_BTN-1:0] : mask_q;
    end

    // Register file, read response and interrupt.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
            mask_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            mask_q   <= mask_d;
            rvalid_q <= rd_hit_w;
            if (rd_hit_w) begin
                rdata_q <= rd_mux_d;
            end
            irq_q <= |(sticky_q & mask_q);
        end
    end

    // Upper write-data bits have no storage behind them when NUM_BTN < 8.
    logic unused_wdata;
    assign unused_wdata = ^bus.BUS_WDATA;

    assign bus.BUS_RDATA  = rdata_q;
    assign bus.BUS_RVALID = rvalid_q;
    assign BTN_LEVEL      = level_w;
    assign BTN_PRESS      = press_w;
    assign IRQ            = irq_q;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Directed bench for btn_input_ctrl with a run-length behavioural model.
`timescale 1ns/1ps
module tb_btn_input_ctrl;
    import btn_input_pkg::*;

    localparam int          NB     = 4;
    localparam logic [25:0] DB     = DEBOUNCE_CNT_SIM;
    localparam int          STABLE = int'(DB) + 2;

    logic          clk_sys = 1'b0;
    logic          rst_n   = 1'b0;
    logic [NB-1:0] BTN_IN  = '0;
    logic [NB-1:0] BTN_LEVEL;
    logic [NB-1:0] BTN_PRESS;
    logic          IRQ;

    btn_input_ctrl_if bus_if();

    btn_input_ctrl #(
        .NUM_BTN      (NB),
        .DEBOUNCE_CNT (DB),
        .BASE_ADDR    (8'hC0)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .BTN_IN    (BTN_IN),
        .bus       (bus_if.slave),
        .BTN_LEVEL (BTN_LEVEL),
        .BTN_PRESS (BTN_PRESS),
        .IRQ       (IRQ)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Debounced level flips once the delayed input has disagreed with it for
    // STABLE consecutive cycles; registers follow the register-map rules.
    logic [NB-1:0] p1, p2, m_level, m_press, m_sticky, m_mask;
    int            m_run [NB];
    logic [7:0]    m_rdata;
    logic          m_rvalid, m_irq;
    logic [7:0]    m_off;
    logic          m_rd_hit;

    assign m_off    = bus_if.BUS_ADDR - 8'hC0;
    assign m_rd_hit = bus_if.BUS_RD && (m_off < 8'd3);

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= '0; p2 <= '0; m_level <= '0; m_press <= '0;
            m_sticky <= '0; m_mask <= '0; m_rdata <= '0; m_rvalid <= 1'b0; m_irq <= 1'b0;
            for (int i = 0; i < NB; i++) m_run[i] <= 0;
        end else begin
            p1 <= BTN_IN;
            p2 <= p1;
            m_press <= '0;
            for (int i = 0; i < NB; i++) begin
                if (p2[i] != m_level[i]) begin
                    if (m_run[i] == STABLE - 1) begin
                        m_level[i] <= ~m_level[i];
                        m_run[i]   <= 0;
                        if (!m_level[i]) m_press[i] <= 1'b1;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end else begin
                    m_run[i] <= 0;
                end
            end
            m_rvalid <= m_rd_hit;
            if (m_rd_hit)
                m_rdata <= (m_off == 8'd0) ? {4'b0, m_level} :
                           (m_off == 8'd1) ? {4'b0, m_sticky} : {4'b0, m_mask};
            m_sticky <= (m_rd_hit && m_off == 8'd1) ? m_press : (m_sticky | m_press);
            if (bus_if.BUS_WE && m_off == 8'd2) m_mask <= bus_if.BUS_WDATA[NB-1:0];
            m_irq <= |(m_sticky & m_mask);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_sys) begin
        if (rst_n) begin
            chk("cyc_level",  BTN_LEVEL,         m_level);
            chk("cyc_press",  BTN_PRESS,         m_press);
            chk("cyc_irq",    IRQ,               m_irq);
            chk("cyc_rvalid", bus_if.BUS_RVALID, m_rvalid);
            chk("cyc_rdata",  bus_if.BUS_RDATA,  m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic v);
        bus_if.BUS_ADDR = a;
        bus_if.BUS_RD   = 1'b1;
        @(posedge clk_sys);
        #1;
        bus_if.BUS_RD = 1'b0;
        d = bus_if.BUS_RDATA;
        v = bus_if.BUS_RVALID;
        $display("read  addr=%02h data=%02h valid=%0b", a, d, v);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus_if.BUS_ADDR  = a;
        bus_if.BUS_WDATA = d;
        bus_if.BUS_WE    = 1'b1;
        @(posedge clk_sys);
        #1;
        bus_if.BUS_WE = 1'b0;
        $display("write addr=%02h data=%02h", a, d);
    endtask

    task automatic wait_press(input int idx);
        int n;
        n = 0;
        while (!BTN_PRESS[idx] && n < 50) begin
            tick(1);
            n++;
        end
        chk("press_timeout", 32'(BTN_PRESS[idx]), 32'd1);
    endtask

    task automatic read_expect(input string name, input logic [7:0] a,
                               input logic [7:0] exp_d, input logic exp_v);
        logic [7:0] d;
        logic       v;
        bus_read(a, d, v);
        chk({name, "_valid"}, 32'(v), 32'(exp_v));
        if (exp_v) chk({name, "_data"}, 32'(d), 32'(exp_d));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int hits;
        bus_if.BUS_ADDR = '0; bus_if.BUS_RD = 1'b0; bus_if.BUS_WE = 1'b0; bus_if.BUS_WDATA = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Reset mid-count while button 1 is held; it must report after release.
        BTN_IN[1] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("rst_level",  32'(BTN_LEVEL), 32'd0);
        chk("rst_press",  32'(BTN_PRESS), 32'd0);
        chk("rst_irq",    32'(IRQ), 32'd0);
        chk("rst_rvalid", 32'(bus_if.BUS_RVALID), 32'd0);
        chk("rst_rdata",  32'(bus_if.BUS_RDATA), 32'd0);
        tick(2);
        rst_n = 1'b1;
        read_expect("rst_sticky", 8'hC1, 8'h00, 1'b1);
        wait_press(1);
        tick(2);
        read_expect("held_sticky", 8'hC1, 8'h02, 1'b1);
        BTN_IN[1] = 1'b0;
        tick(12);

        // Clean press: level rises exactly 8 edges after the input change.
        BTN_IN[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 7) chk("clean_level_early", 32'(BTN_LEVEL[0]), 32'd0);
            if (k == 8) begin
                chk("clean_level_on", 32'(BTN_LEVEL[0]), 32'd1);
                chk("clean_press_on", 32'(BTN_PRESS[0]), 32'd1);
            end
        end
        hits = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (BTN_PRESS[0]) hits++;
        end
        chk("clean_press_single", 32'(hits), 32'd0);
        read_expect("clean_sticky1", 8'hC1, 8'h01, 1'b1);
        read_expect("clean_sticky2", 8'hC1, 8'h00, 1'b1);
        BTN_IN[0] = 1'b0;
        tick(12);

        // Bounce: toggling every 3 cycles never settles.
        hits = 0;
        for (int t = 0; t < 10; t++) begin
            BTN_IN[1] = ~BTN_IN[1];
            for (int k = 0; k < 3; k++) begin
                tick(1);
                if (BTN_LEVEL[1] || BTN_PRESS[1]) hits++;
            end
        end
        BTN_IN[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (BTN_LEVEL[1] || BTN_PRESS[1]) hits++;
        end
        chk("bounce_never_high", 32'(hits), 32'd0);
        read_expect("bounce_sticky", 8'hC1, 8'h00, 1'b1);

        // Masked interrupt on button 2.
        bus_write(8'hC2, 8'h04);
        BTN_IN[2] = 1'b1;
        wait_press(2);
        tick(1);
        chk("irq_not_yet", 32'(IRQ), 32'd0);
        tick(1);
        chk("irq_raised", 32'(IRQ), 32'd1);
        read_expect("irq_sticky", 8'hC1, 8'h04, 1'b1);
        tick(1);
        chk("irq_dropped", 32'(IRQ), 32'd0);
        BTN_IN[2] = 1'b0;
        tick(12);
        bus_write(8'hC2, 8'h00);
        BTN_IN[3] = 1'b1;
        wait_press(3);
        tick(3);
        chk("irq_masked", 32'(IRQ), 32'd0);
        read_expect("unmasked_sticky", 8'hC1, 8'h08, 1'b1);
        BTN_IN[3] = 1'b0;
        tick(12);

        // Clearing read collides with a fresh press: set wins.
        BTN_IN[0] = 1'b1;
        tick(8);
        chk("coll_press", 32'(BTN_PRESS[0]), 32'd1);
        read_expect("coll_read", 8'hC1, 8'h00, 1'b1);
        read_expect("coll_survive", 8'hC1, 8'h01, 1'b1);

        // Address decode.
        read_expect("unmapped_c3", 8'hC3, 8'h00, 1'b0);
        read_expect("foreign_40", 8'h40, 8'h00, 1'b0);
        BTN_IN[2] = 1'b1;
        tick(12);
        read_expect("level_05", 8'hC0, 8'h05, 1'b1);
        read_expect("mask_00", 8'hC2, 8'h00, 1'b1);
        BTN_IN = '0;
        tick(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
